// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: bus widths and AXI4-Lite response encoding shared by bus users
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif
package axi4lite_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;
endpackage

// File: rtl/axi4lite_if.sv
// axi4lite: AXI4-Lite bus bundle with master and slave views
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif
interface axi4lite (
  input logic aclk,
  input logic aresetn
);
  logic [`ALEN-1:0]   awaddr;
  logic               awvalid;
  logic               awready;
  logic [`XLEN-1:0]   wdata;
  logic [`XLEN/8-1:0] wstrb;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [`ALEN-1:0]   araddr;
  logic               arvalid;
  logic               arready;
  logic [`XLEN-1:0]   rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;
  modport slave (
    input  aclk, aresetn, awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    input  aclk, aresetn, awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
  );
endinterface

// File: rtl/sram_1rw.sv
// sram_1rw: single-port word RAM with byte enables and a registered read, no reset
module sram_1rw #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            en_i,
  input  logic [DW/8-1:0] we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < DW/8; i++)
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      if (we_i == '0) rdata_q <= mem_q[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi4lite_sram.sv
// axi4lite_sram: AXI4-Lite responder in front of a single-port SRAM, one transaction at a time
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif
module axi4lite_sram
  import axi4lite_pkg::*;
#(
  parameter logic [`ALEN-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int               DEPTH_WORDS = 1024
) (
  input  logic   clk,
  input  logic   aresetn,
  axi4lite.slave sys_bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [`ALEN-1:0] SPAN = `ALEN'(4 * DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WR_COLLECT, WR_RESP, RD_RESP} state_e;
  state_e             state_q;
  logic               awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
  resp_e              bresp_q, rresp_q;
  logic [`ALEN-1:0]   awaddr_q;
  logic [`XLEN-1:0]   wdata_q;
  logic [`XLEN/8-1:0] wstrb_q;
  logic               aw_hs, w_hs, ar_hs, commit, wr_hit, rd_hit, sram_en;
  logic [`ALEN-1:0]   wr_addr;
  logic [`XLEN-1:0]   wr_data, sram_rdata;
  logic [`XLEN/8-1:0] wr_strb, sram_we;
  logic [IW-1:0]      sram_addr;
  logic               unused;
  function automatic logic hit(input logic [`ALEN-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction
  function automatic logic [IW-1:0] idx(input logic [`ALEN-1:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction
  assign unused = sys_bus.aclk ^ sys_bus.aresetn;
  assign sys_bus.awready = awready_q;
  assign sys_bus.wready  = wready_q;
  assign sys_bus.arready = arready_q && !sys_bus.awvalid && !sys_bus.wvalid;
  assign sys_bus.bvalid  = bvalid_q;
  assign sys_bus.bresp   = bresp_q;
  assign sys_bus.rvalid  = rvalid_q;
  assign sys_bus.rresp   = rresp_q;
  assign sys_bus.rdata   = (rvalid_q && rresp_q == RESP_OKAY) ? sram_rdata : '0;
  // A ready still high means that channel has not been captured yet, so take it live
  always_comb begin
    aw_hs     = sys_bus.awvalid && awready_q;
    w_hs      = sys_bus.wvalid && wready_q;
    ar_hs     = sys_bus.arvalid && sys_bus.arready;
    commit    = (awready_q ? aw_hs : 1'b1) && (wready_q ? w_hs : 1'b1) && (aw_hs || w_hs);
    wr_addr   = awready_q ? sys_bus.awaddr : awaddr_q;
    wr_data   = wready_q ? sys_bus.wdata : wdata_q;
    wr_strb   = wready_q ? sys_bus.wstrb : wstrb_q;
    wr_hit    = hit(wr_addr);
    rd_hit    = hit(sys_bus.araddr);
    sram_addr = commit ? idx(wr_addr) : idx(sys_bus.araddr);
    sram_en   = (commit && wr_hit) || (ar_hs && rd_hit);
    sram_we   = (commit && wr_hit) ? wr_strb : '0;
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (commit) begin
      state_q <= WR_RESP;
      {awready_q, wready_q, arready_q} <= 3'b000;
      bvalid_q <= 1'b1;
      bresp_q  <= wr_hit ? RESP_OKAY : RESP_DECERR;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            state_q   <= WR_COLLECT;
            awaddr_q  <= sys_bus.awaddr;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
          end else if (w_hs) begin
            state_q   <= WR_COLLECT;
            wdata_q   <= sys_bus.wdata;
            wstrb_q   <= sys_bus.wstrb;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
          end else if (ar_hs) begin
            state_q  <= RD_RESP;
            {awready_q, wready_q, arready_q} <= 3'b000;
            rvalid_q <= 1'b1;
            rresp_q  <= rd_hit ? RESP_OKAY : RESP_DECERR;
          end else begin
            {awready_q, wready_q, arready_q} <= 3'b111;
          end
        end
        WR_RESP: if (sys_bus.bready) begin
          state_q  <= IDLE;
          bvalid_q <= 1'b0;
          {awready_q, wready_q, arready_q} <= 3'b111;
        end
        RD_RESP: if (sys_bus.rready) begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          {awready_q, wready_q, arready_q} <= 3'b111;
        end
        default: ;
      endcase
    end
  end
  sram_1rw #(.DEPTH(DEPTH_WORDS), .DW(`XLEN)) u_sram (
    .clk    (clk),
    .en_i   (sram_en),
    .we_i   (sram_we),
    .addr_i (sram_addr),
    .wdata_i(wr_data),
    .rdata_o(sram_rdata)
  );
endmodule

// File: tb/tb_axi4lite_sram.sv
// tb_axi4lite_sram: randomized and directed checks of axi4lite_sram against a word-array model
module tb_axi4lite_sram;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] model [int];
  always #5 clk = ~clk;
  axi4lite bus (.aclk(clk), .aresetn(aresetn));
  axi4lite_sram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk    (clk),
    .aresetn(aresetn),
    .sys_bus(bus)
  );
  function automatic bit in_range(input logic [31:0] a);
    longint x = longint'(a);
    return x >= longint'(BASE) && x < longint'(BASE) + 4 * DEPTH;
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction
  function automatic void apply_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!in_range(a)) return;
    w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model[widx(a)] = w;
  endfunction
  function automatic logic [31:0] expect_rd(input logic [31:0] a);
    return in_range(a) ? model[widx(a)] : 32'h0;
  endfunction
  function automatic logic [1:0] expect_resp(input logic [31:0] a);
    return in_range(a) ? 2'b00 : 2'b11;
  endfunction
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit bv_next, output bit tmo);
    int n;
    bit ha, hw;
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    n = 0; tmo = 0;
    while ((bus.awvalid || bus.wvalid) && n < 20) begin
      #1;
      ha = bus.awvalid && bus.awready;
      hw = bus.wvalid && bus.wready;
      @(negedge clk);
      if (ha) bus.awvalid = 1'b0;
      if (hw) bus.wvalid = 1'b0;
      n++;
    end
    if (bus.awvalid || bus.wvalid) begin
      tmo = 1; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end
    #1 bv_next = bus.bvalid;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); #1; n++; end
    if (!bus.bvalid) tmo = 1;
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask
  task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                         output bit rv_next, output bit tmo);
    int n;
    bit h;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0; tmo = 0;
    while (bus.arvalid && n < 20) begin
      #1 h = bus.arvalid && bus.arready;
      @(negedge clk);
      if (h) bus.arvalid = 1'b0;
      n++;
    end
    if (bus.arvalid) begin tmo = 1; bus.arvalid = 1'b0; end
    #1 rv_next = bus.rvalid;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); #1; n++; end
    if (!bus.rvalid) tmo = 1;
    data = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask
  task automatic test_reset();
    logic [13:0] outs;
    #2;
    outs = {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready, bus.bresp, bus.rresp, bus.rdata[4:0]};
    checks++;
    if (outs !== '0 || bus.rdata !== '0) begin errors++; $display("FAIL reset_outputs: got %h rdata %h want 0", outs, bus.rdata); end
    @(negedge clk); @(negedge clk);
    aresetn = 1'b1;
    #1; checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin errors++; $display("FAIL first_edge_readys: got %b want 000", {bus.awready, bus.wready, bus.arready}); end
    @(negedge clk); #1; checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin errors++; $display("FAIL idle_readys: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
  endtask
  task automatic test_same_cycle();
    logic [1:0] resp; logic [31:0] d; bit nxt, tmo;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, nxt, tmo);
    apply_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (tmo || !nxt || resp !== 2'b00) begin errors++; $display("FAIL same_cycle_write: tmo %0d bvalid_next %0d resp %b want 0 1 00", tmo, nxt, resp); end
    do_read(32'h8000_0010, d, resp, nxt, tmo);
    checks++;
    if (tmo || !nxt || resp !== 2'b00 || d !== expect_rd(32'h8000_0010)) begin errors++; $display("FAIL same_cycle_read: tmo %0d rvalid_next %0d resp %b data %h want 0 1 00 %h", tmo, nxt, resp, d, expect_rd(32'h8000_0010)); end
  endtask
  task automatic test_w_before_aw();
    logic [1:0] resp; logic [31:0] d; bit nxt, tmo;
    @(negedge clk);
    bus.wdata = 32'h1122_3344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin errors++; $display("FAIL w_wait_%0d: wready %b bvalid %b want 0 0", i, bus.wready, bus.bvalid); end
      @(negedge clk);
    end
    bus.awaddr = 32'h8000_0020; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    #1; checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin errors++; $display("FAIL w_first_bvalid: bvalid %b bresp %b want 1 00", bus.bvalid, bus.bresp); end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    apply_write(32'h8000_0020, 32'h1122_3344, 4'hF);
    do_read(32'h8000_0020, d, resp, nxt, tmo);
    checks++;
    if (tmo || d !== expect_rd(32'h8000_0020)) begin errors++; $display("FAIL w_first_read: tmo %0d data %h want %h", tmo, d, expect_rd(32'h8000_0020)); end
  endtask
  task automatic test_strobe();
    logic [1:0] resp; logic [31:0] d; bit nxt, tmo;
    do_write(BASE, 32'h0, 4'hF, resp, nxt, tmo);
    apply_write(BASE, 32'h0, 4'hF);
    do_write(BASE, 32'hAAAA_AAAA, 4'b0010, resp, nxt, tmo);
    apply_write(BASE, 32'hAAAA_AAAA, 4'b0010);
    do_read(BASE, d, resp, nxt, tmo);
    checks++;
    if (tmo || d !== expect_rd(BASE) || d !== 32'h0000_AA00) begin errors++; $display("FAIL strb_0010: data %h want %h", d, expect_rd(BASE)); end
    do_write(BASE, 32'hFFFF_FFFF, 4'h0, resp, nxt, tmo);
    checks++;
    if (tmo || resp !== 2'b00) begin errors++; $display("FAIL strb_zero_resp: tmo %0d resp %b want 00", tmo, resp); end
    do_read(BASE, d, resp, nxt, tmo);
    checks++;
    if (d !== expect_rd(BASE)) begin errors++; $display("FAIL strb_zero_data: data %h want %h", d, expect_rd(BASE)); end
  endtask
  task automatic test_decerr();
    logic [1:0] resp; logic [31:0] d; bit nxt, tmo;
    do_read(32'h8000_1000, d, resp, nxt, tmo);
    checks++;
    if (tmo || resp !== 2'b11 || d !== 32'h0) begin errors++; $display("FAIL decerr_read: resp %b data %h want 11 00000000", resp, d); end
    do_write(32'h7FFF_FFFC, 32'h5A5A_5A5A, 4'hF, resp, nxt, tmo);
    checks++;
    if (tmo || resp !== 2'b11) begin errors++; $display("FAIL decerr_write_low: resp %b want 11", resp); end
    do_write(32'h8000_1000, 32'hA5A5_A5A5, 4'hF, resp, nxt, tmo);
    checks++;
    if (tmo || resp !== 2'b11) begin errors++; $display("FAIL decerr_write_high: resp %b want 11", resp); end
    do_write(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, resp, nxt, tmo);
    apply_write(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF);
    checks++;
    if (tmo || resp !== 2'b00) begin errors++; $display("FAIL last_word_write: resp %b want 00", resp); end
    foreach (model[k]) begin
      do_read(BASE + 32'(4 * k), d, resp, nxt, tmo);
      checks++;
      if (tmo || resp !== 2'b00 || d !== model[k]) begin errors++; $display("FAIL decerr_untouched_%0d: resp %b data %h want 00 %h", k, resp, d, model[k]); end
    end
  endtask
  task automatic test_write_priority();
    logic [31:0] a, wd, d0;
    a = 32'h8000_0040; wd = $urandom;
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = a; bus.arvalid = 1'b1;
    #1; checks++;
    if (bus.arready !== 1'b0) begin errors++; $display("FAIL prio_arready_idle: got %b want 0", bus.arready); end
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    apply_write(a, wd, 4'hF);
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (bus.arready !== 1'b0 || bus.bvalid !== 1'b1) begin errors++; $display("FAIL prio_wr_resp_%0d: arready %b bvalid %b want 0 1", i, bus.arready, bus.bvalid); end
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    #1; checks++;
    if (bus.arready !== 1'b1 || bus.bvalid !== 1'b0) begin errors++; $display("FAIL prio_after_b: arready %b bvalid %b want 1 0", bus.arready, bus.bvalid); end
    @(negedge clk);
    bus.arvalid = 1'b0;
    #1; checks++;
    d0 = bus.rdata;
    if (bus.rvalid !== 1'b1 || d0 !== expect_rd(a)) begin errors++; $display("FAIL prio_read: rvalid %b data %h want 1 %h", bus.rvalid, d0, expect_rd(a)); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1; checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== d0) begin errors++; $display("FAIL r_hold_%0d: rvalid %b data %h want 1 %h", i, bus.rvalid, bus.rdata, d0); end
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    #1; checks++;
    if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL r_release: rvalid %b want 0", bus.rvalid); end
  endtask
  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] d; bit nxt, tmo;
    do_write(32'h8000_0080, 32'h0BAD_F00D, 4'hF, resp, nxt, tmo);
    apply_write(32'h8000_0080, 32'h0BAD_F00D, 4'hF);
    @(negedge clk);
    bus.awaddr = 32'h8000_0080; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1; checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b0) begin errors++; $display("FAIL async_reset: got %b want 00000", {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}); end
    @(negedge clk); @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    do_write(32'h8000_0084, 32'h1357_9BDF, 4'hF, resp, nxt, tmo);
    apply_write(32'h8000_0084, 32'h1357_9BDF, 4'hF);
    checks++;
    if (tmo || resp !== 2'b00) begin errors++; $display("FAIL post_reset_write: tmo %0d resp %b want 00", tmo, resp); end
    do_read(32'h8000_0080, d, resp, nxt, tmo);
    checks++;
    if (tmo || d !== expect_rd(32'h8000_0080)) begin errors++; $display("FAIL reset_discard: data %h want %h", d, expect_rd(32'h8000_0080)); end
    do_read(32'h8000_0084, d, resp, nxt, tmo);
    checks++;
    if (tmo || d !== expect_rd(32'h8000_0084)) begin errors++; $display("FAIL post_reset_read: data %h want %h", d, expect_rd(32'h8000_0084)); end
  endtask
  task automatic test_random();
    logic [1:0] resp; logic [31:0] a, d; logic [3:0] s; bit nxt, tmo;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_write(BASE + 32'(4 * i), d, 4'hF, resp, nxt, tmo);
      apply_write(BASE + 32'(4 * i), d, 4'hF);
    end
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0: a = BASE - 32'(4 * $urandom_range(1, 64));
        1: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 1023));
        default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        do_write(a, d, s, resp, nxt, tmo);
        apply_write(a, d, s);
        checks++;
        if (tmo || !nxt || resp !== expect_resp(a)) begin errors++; $display("FAIL rand_write_%0d: addr %h tmo %0d bnext %0d resp %b want %b", i, a, tmo, nxt, resp, expect_resp(a)); end
      end else begin
        do_read(a, d, resp, nxt, tmo);
        checks++;
        if (tmo || !nxt || resp !== expect_resp(a) || d !== expect_rd(a)) begin errors++; $display("FAIL rand_read_%0d: addr %h resp %b data %h want %b %h", i, a, resp, d, expect_resp(a), expect_rd(a)); end
      end
    end
  endtask
  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_strobe();
    test_decerr();
    test_write_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
